// File: rtl/stopwatch_counter_pkg.sv
// Shared constants and run-state type for the stopwatch counter.
package stopwatch_counter_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_MAX        = 99;
    localparam int DEF_TICK_DIV   = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } run_state_t;

    function automatic int prescale_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_counter_tick_prescaler.sv
// Divides enabled clocks by TICK_DIV; the phase is kept while disabled.
module stopwatch_counter_tick_prescaler
    import stopwatch_counter_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int            PW   = prescale_width(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] phase_q;
    logic          at_last;

    // With TICK_DIV==1 the phase is pinned at 0, so tick follows enable.
    assign at_last = (phase_q == LAST);
    assign tick    = enable & at_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= '0;
        end else if (enable) begin
            phase_q <= at_last ? '0 : phase_q + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Run/stop stopwatch: latched run flag, prescaled count wrapping at MAX.
module stopwatch_counter
    import stopwatch_counter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX        = DEF_MAX,
    parameter int TICK_DIV   = DEF_TICK_DIV
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    output logic [DATA_WIDTH-1:0] count
);

    localparam logic [DATA_WIDTH-1:0] MAX_V = DATA_WIDTH'(MAX);

    run_state_t            state_q;
    run_state_t            state_d;
    logic                  enable;
    logic                  tick;
    logic [DATA_WIDTH-1:0] count_q;
    logic [DATA_WIDTH-1:0] count_d;

    // Stop wins over start; counting follows the flag being set this edge.
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = RUN;
        end
        enable = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    stopwatch_counter_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    always_comb begin
        count_d = count_q;
        if (tick) begin
            count_d = (count_q == MAX_V) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench: default instance plus a prescaled, small-wrap instance.
module tb_stopwatch_counter;

    localparam int DIV [2] = '{1, 3};
    localparam int MXV [2] = '{99, 9};

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [15:0] count1;
    logic [3:0]  count2;

    int n_tests = 0;
    int n_fail  = 0;

    bit m_run;
    int m_cnt [2];
    int m_ph  [2];

    always #5 clk = ~clk;

    stopwatch_counter dut1 (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .count (count1)
    );

    stopwatch_counter #(
        .DATA_WIDTH (4),
        .MAX        (9),
        .TICK_DIV   (3)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .count (count2)
    );

    task automatic model_clear();
        m_run = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0;
            m_ph[k]  = 0;
        end
    endtask

    task automatic model_edge(input logic st, input logic sp);
        if (reset !== 1'b1) begin
            model_clear();
            return;
        end
        if (sp) m_run = 1'b0;
        else if (st) m_run = 1'b1;
        if (m_run) begin
            for (int k = 0; k < 2; k++) begin
                m_ph[k] = m_ph[k] + 1;
                if (m_ph[k] == DIV[k]) begin
                    m_ph[k]  = 0;
                    m_cnt[k] = (m_cnt[k] + 1) % (MXV[k] + 1);
                end
            end
        end
    endtask

    task automatic cyc(input logic st, input logic sp);
        start = st;
        stop  = sp;
        @(posedge clk);
        model_edge(st, sp);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'bx;
        stop  = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (count1 !== 16'd0 || count2 !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_hold: count1=%0d count2=%0d required 0/0",
                     count1, count2);
        end
        start = 1'b0;
        #3 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0);
            n_tests++;
            if (count1 !== 16'd0 || count2 !== 4'd0) begin
                n_fail++;
                $display("FAIL idle_after_reset[%0d]: count1=%0d count2=%0d required 0/0",
                         i, count1, count2);
            end
        end
    endtask

    task automatic test_start_pulse();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0);
            n_tests++;
            if (count1 !== 16'(i + 1) || count2 !== 4'(m_cnt[1])) begin
                n_fail++;
                $display("FAIL start_pulse[%0d]: count1=%0d count2=%0d required %0d/%0d",
                         i, count1, count2, i + 1, m_cnt[1]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0);
            n_tests++;
            if (count1 !== 16'(i + 5) || count2 !== 4'(m_cnt[1])) begin
                n_fail++;
                $display("FAIL free_run[%0d]: count1=%0d count2=%0d required %0d/%0d",
                         i, count1, count2, i + 5, m_cnt[1]);
            end
        end
    endtask

    task automatic test_wrap();
        for (int inc = 11; inc <= 116; inc++) begin
            cyc(1'b0, 1'b0);
            n_tests++;
            if (count1 !== 16'(m_cnt[0]) || count2 !== 4'(m_cnt[1])) begin
                n_fail++;
                $display("FAIL wrap_run[%0d]: count1=%0d count2=%0d required %0d/%0d",
                         inc, count1, count2, m_cnt[0], m_cnt[1]);
            end
            if (inc == 99 || inc == 100 || inc == 116) begin
                n_tests++;
                if (count1 !== 16'(inc % 100)) begin
                    n_fail++;
                    $display("FAIL wrap_point[%0d]: count1=%0d required %0d",
                             inc, count1, inc % 100);
                end
            end
        end
    endtask

    task automatic test_stop_hold(output int n1, output int n2);
        n1 = m_cnt[0];
        n2 = m_cnt[1];
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1);
            n_tests++;
            if (count1 !== 16'(n1) || count2 !== 4'(n2)) begin
                n_fail++;
                $display("FAIL stop_hold[%0d]: count1=%0d count2=%0d required %0d/%0d",
                         i, count1, count2, n1, n2);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1);
            n_tests++;
            if (count1 !== 16'(n1) || count2 !== 4'(n2)) begin
                n_fail++;
                $display("FAIL start_and_stop[%0d]: count1=%0d count2=%0d required %0d/%0d",
                         i, count1, count2, n1, n2);
            end
        end
    endtask

    task automatic test_resume(input int n1);
        cyc(1'b1, 1'b0);
        n_tests++;
        if (count1 !== 16'(n1 + 1) || count2 !== 4'(m_cnt[1])) begin
            n_fail++;
            $display("FAIL resume_first: count1=%0d count2=%0d required %0d/%0d",
                     count1, count2, n1 + 1, m_cnt[1]);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0);
            n_tests++;
            if (count1 !== 16'(n1 + 2 + i) || count2 !== 4'(m_cnt[1])) begin
                n_fail++;
                $display("FAIL resume_run[%0d]: count1=%0d count2=%0d required %0d/%0d",
                         i, count1, count2, n1 + 2 + i, m_cnt[1]);
            end
        end
    endtask

    task automatic test_async_reset();
        int budget;
        budget = 0;
        while (m_cnt[0] != 50 && budget < 200) begin
            cyc(1'b0, 1'b0);
            budget++;
        end
        n_tests++;
        if (count1 !== 16'd50) begin
            n_fail++;
            $display("FAIL reach_50: count1=%0d required 50 after %0d cycles",
                     count1, budget);
        end
        #2 reset = 1'b0;
        model_clear();
        #1;
        n_tests++;
        if (count1 !== 16'd0 || count2 !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset: count1=%0d count2=%0d required 0/0",
                     count1, count2);
        end
        @(posedge clk);
        #3 reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0);
            n_tests++;
            if (count1 !== 16'd0 || count2 !== 4'd0) begin
                n_fail++;
                $display("FAIL idle_after_async[%0d]: count1=%0d count2=%0d required 0/0",
                         i, count1, count2);
            end
        end
        cyc(1'b1, 1'b0);
        n_tests++;
        if (count1 !== 16'd1 || count2 !== 4'(m_cnt[1])) begin
            n_fail++;
            $display("FAIL restart_after_async: count1=%0d count2=%0d required 1/%0d",
                     count1, count2, m_cnt[1]);
        end
    endtask

    task automatic test_random();
        logic st;
        logic sp;
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 3) == 0);
            sp = ($urandom_range(0, 7) == 0);
            cyc(st, sp);
            n_tests++;
            if (count1 !== 16'(m_cnt[0]) || count2 !== 4'(m_cnt[1])) begin
                n_fail++;
                $display("FAIL random[%0d] st=%0b sp=%0b: count1=%0d count2=%0d required %0d/%0d",
                         i, st, sp, count1, count2, m_cnt[0], m_cnt[1]);
            end
        end
    endtask

    initial begin
        int n1;
        int n2;
        test_reset();
        test_start_pulse();
        test_wrap();
        test_stop_hold(n1, n2);
        test_resume(n1);
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
